// File: rtl/bidir_width_conv.sv
// Bidirectional wide<->narrow width converter: unpacks RATIO-word beats into a
// narrow stream (mode 0) or packs a narrow stream into wide beats (mode 1).
module bidir_width_conv #(
  parameter int NW        = 64,
  parameter int RATIO     = 7,
  parameter int CNT_W     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  output logic                busy,
  input  logic [NW*RATIO-1:0] s_wide_data,
  input  logic [CNT_W-1:0]    s_wide_cnt,
  input  logic                s_wide_valid,
  output logic                s_wide_ready,
  output logic [NW-1:0]       m_nar_data,
  output logic                m_nar_valid,
  output logic                m_nar_last,
  input  logic                m_nar_ready,
  input  logic [NW-1:0]       s_nar_data,
  input  logic                s_nar_valid,
  input  logic                s_nar_last,
  output logic                s_nar_ready,
  output logic [NW*RATIO-1:0] m_wide_data,
  output logic [CNT_W-1:0]    m_wide_cnt,
  output logic                m_wide_valid,
  input  logic                m_wide_ready
);

  localparam int WW = NW * RATIO;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit offset of word slot k inside a wide beat.
  function automatic int slot_lo(input int k);
    return (MSB_FIRST != 0) ? WW - (k + 1) * NW : k * NW;
  endfunction

  logic             mode_q;
  logic             held;
  logic [WW-1:0]    hold_reg;
  logic [CNT_W-1:0] rd_idx;
  logic [CNT_W-1:0] n_q;
  logic [WW-1:0]    acc;
  logic [CNT_W-1:0] wr_cnt;

  // Valid/ready: a word or beat moves on a clk edge where valid && ready are
  // both high; valid never looks at ready, and data/cnt/last stay put while
  // valid is high and ready is low.
  logic             wide_fire;
  logic             nar_fire;
  logic             nar_in_fire;
  logic             closing;
  logic             out_stall;
  logic [CNT_W-1:0] wide_n;
  logic [NW-1:0]    sel_word;
  logic [WW-1:0]    pack_beat;

  assign busy = held || (wr_cnt != '0) || m_wide_valid;

  // Unpack side
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < RATIO; k++)
      if (rd_idx == CNT_W'(k)) sel_word = hold_reg[slot_lo(k) +: NW];
  end

  assign m_nar_valid  = !mode_q && held;
  assign m_nar_data   = m_nar_valid ? sel_word : '0;
  assign m_nar_last   = m_nar_valid && (rd_idx == n_q - CNT_ONE);
  assign nar_fire     = m_nar_valid && m_nar_ready;
  assign s_wide_ready = !mode_q && (!held || (nar_fire && m_nar_last));
  assign wide_fire    = s_wide_valid && s_wide_ready;
  assign wide_n       = (s_wide_cnt == '0 || s_wide_cnt > CNT_FULL) ? CNT_FULL : s_wide_cnt;

  // Pack side: slot 0 starts from a cleared beat so unused slots read as zero.
  always_comb begin
    pack_beat = (wr_cnt == '0) ? '0 : acc;
    for (int k = 0; k < RATIO; k++)
      if (wr_cnt == CNT_W'(k)) pack_beat[slot_lo(k) +: NW] = s_nar_data;
  end

  assign closing     = (wr_cnt == CNT_LAST) || s_nar_last;
  assign out_stall   = m_wide_valid && !m_wide_ready;
  assign s_nar_ready = mode_q && (!out_stall || !closing);
  assign nar_in_fire = s_nar_valid && s_nar_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= 1'b0;
      held         <= 1'b0;
      hold_reg     <= '0;
      rd_idx       <= '0;
      n_q          <= '0;
      acc          <= '0;
      wr_cnt       <= '0;
      m_wide_data  <= '0;
      m_wide_cnt   <= '0;
      m_wide_valid <= 1'b0;
    end else begin
      // A transfer on this edge makes the block busy, so mode must not move with it.
      if (!busy && !wide_fire && !nar_in_fire) mode_q <= mode;

      if (wide_fire) begin
        hold_reg <= s_wide_data;
        n_q      <= wide_n;
        rd_idx   <= '0;
        held     <= 1'b1;
      end else if (nar_fire) begin
        if (m_nar_last) held <= 1'b0;
        else            rd_idx <= rd_idx + CNT_ONE;
      end

      if (nar_in_fire) begin
        acc <= pack_beat;
        if (closing) begin
          m_wide_data  <= pack_beat;
          m_wide_cnt   <= wr_cnt + CNT_ONE;
          m_wide_valid <= 1'b1;
          wr_cnt       <= '0;
        end else begin
          wr_cnt <= wr_cnt + CNT_ONE;
        end
      end

      if (m_wide_valid && m_wide_ready && !(nar_in_fire && closing))
        m_wide_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bidir_width_conv.md
Name: bidir_width_conv

Overview:
- Parametrised successor of the fixed 448<->64 bidirectional width converter.
- Converts between a wide bus of RATIO narrow words and a narrow bus of NW bits, in either direction selected by `mode`.
- Adds valid/ready backpressure on all four interfaces, partial beats with explicit word counts, and zero-bubble back-to-back transfers.
- Sits between wide datapath RAM/buffers and the 64-bit stream interfaces (pack/unpack of S/E' and tail data).

Parameters:
- NW, 64: narrow word width in bits.
- RATIO, 7: narrow words per wide beat; WW = NW*RATIO is a derived localparam (448 at defaults).
- CNT_W, 3: word-count width; must satisfy 2^CNT_W > RATIO.
- MSB_FIRST, 1: 1 = word k occupies bits [WW-1-k*NW -: NW]; 0 = word k occupies bits [k*NW +: NW].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mode  in  1  0 = unpack (wide->narrow), 1 = pack (narrow->wide)
- busy  out  1  any data held in the block
- s_wide_data  in  WW  unpack input beat
- s_wide_cnt  in  CNT_W  valid words in beat; 0 or >RATIO means RATIO
- s_wide_valid  in  1  unpack input valid
- s_wide_ready  out  1  unpack input ready
- m_nar_data  out  NW  unpack output word
- m_nar_valid  out  1  unpack output valid
- m_nar_last  out  1  final word of the current wide beat
- m_nar_ready  in  1  unpack output ready
- s_nar_data  in  NW  pack input word
- s_nar_valid  in  1  pack input valid
- s_nar_last  in  1  flush: this word closes the wide beat
- s_nar_ready  out  1  pack input ready
- m_wide_data  out  WW  pack output beat
- m_wide_cnt  out  CNT_W  words filled in m_wide_data (1..RATIO)
- m_wide_valid  out  1  pack output valid
- m_wide_ready  in  1  pack output ready

Behaviour:
- Reset: every register cleared; all data outputs 0; m_nar_valid, m_nar_last, m_wide_valid, busy = 0; m_wide_cnt = 0; mode_q = 0.
- Reset asserted mid-operation discards any partial accumulation and any unsent words.
- Handshakes:
  - A transfer occurs on a clk edge where valid && ready.
  - Valid must not depend on ready.
  - Data, cnt and last are held stable while valid && !ready.
- Mode:
  - `mode` is registered into mode_q only while busy = 0; changes while busy are deferred until idle.
  - Inactive-direction ready outputs are 0 and inactive-direction valid outputs are 0.
- Unpack (mode_q = 0): one WW holding register, word index rd_idx, and latched count n.
  - s_wide_ready = !held || (m_nar_valid && m_nar_ready && m_nar_last). This allows zero-bubble back-to-back beats.
  - On accept: latch data and n, set rd_idx = 0. The first word is presented on m_nar_data in the following cycle.
  - m_nar_data = word rd_idx per MSB_FIRST; m_nar_last = (rd_idx == n-1).
  - Each narrow handshake increments rd_idx. Handshake on the last word frees the register, unless a new beat is accepted on the same edge.
  - Words at index >= n are never emitted.
- Pack (mode_q = 1): accumulator acc, word counter wr_cnt, and output register {m_wide_data, m_wide_cnt, m_wide_valid}.
  - Each accepted narrow word is written to word slot wr_cnt per MSB_FIRST.
  - Slot 0 clears all other slots, so unused slots are 0 on flush.
  - Close condition: wr_cnt == RATIO-1 or s_nar_last. On close, the completed beat (including the closing word) moves to the output register with m_wide_cnt = wr_cnt+1, and wr_cnt returns to 0.
  - m_wide_valid asserts the cycle after the closing handshake (latency 1).
  - s_nar_ready = !(m_wide_valid && !m_wide_ready) || !closing. The accumulator keeps filling while the output is stalled; only the closing word waits.
  - With m_wide_ready held at 1, continuous narrow input runs with no bubble.
  - s_nar_last on word RATIO-1 is identical to a normal full close.
- Round-trip invariant: for equal MSB_FIRST, pack followed by unpack reproduces the narrow sequence, and m_wide_cnt equals the s_wide_cnt required.
- busy = held || wr_cnt != 0 || m_wide_valid.

Test Plan:
- Unpack full beat: mode=0, s_wide_cnt=7, words W0..W6 = 64'h1..64'h7 per MSB_FIRST=1, m_nar_ready=1 -> m_nar_data = 1,2,...,7 on 7 consecutive cycles; m_nar_last only on 7; s_wide_ready high in the 7th cycle.
- Unpack partial + backpressure: s_wide_cnt=3, m_nar_ready toggling 1,0,1,0,1 -> exactly 3 words emitted, each held stable while stalled; last on the 3rd word.
- Pack back-to-back: mode=1, 14 words 64'hA0..64'hAD continuous, m_wide_ready=1 -> two beats, cnt=7 each; beat 1 top word = A0, beat 2 top word = A7; s_nar_ready stays 1.
- Pack flush: 3 words with s_nar_last on the 3rd, then 2 more words -> beat 1 has cnt=3 and the low 4 words zero; the next beat starts clean.
- Output stall: m_wide_ready=0 while 13 words arrive -> s_nar_ready drops only on the 14th (closing) word; it releases on the cycle m_wide_ready=1.
- Mode/reset: mode toggled while busy -> ignored until the drain completes. rst pulsed mid-pack after 4 words -> all valids 0, busy 0, and the next beat starts at slot 0.
